// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N producers share one FIFO write port,
// each grant holds the port for up to BURST words.
module fifo_wr_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                      wrclk,
    input  logic                      wr_rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           gnt,
    input  logic                      full,
    output logic                      push,
    output logic [WIDTH-1:0]          data_in,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      owner_vld
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state;
    logic [OW-1:0] owner_q;
    logic [OW-1:0] last_owner;
    logic [CW-1:0] cnt;
    logic [OW-1:0] pick;
    logic          in_grant;
    logic          accept;
    logic          last_word;

    // First requester at or after last_owner+1, wrapping.
    function automatic logic [OW-1:0] rr_pick(
        input logic [NREQ-1:0] r,
        input logic [OW-1:0]   last
    );
        logic [OW-1:0] sel;
        int            idx;
        sel = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(last) + 1 + k) % NREQ;
            if (r[idx]) sel = OW'(idx);
        end
        return sel;
    endfunction

    assign pick      = rr_pick(req, last_owner);
    assign in_grant  = (state == GRANT) && !wr_rst;
    assign accept    = in_grant && req[owner_q] && !full;
    assign last_word = (cnt == CW'(BURST - 1));

    assign owner_vld = in_grant;
    assign owner     = wr_rst ? '0 : owner_q;
    assign push      = accept;
    assign gnt       = NREQ'(accept) << owner_q;
    assign data_in   = in_grant ? req_data[owner_q*WIDTH +: WIDTH] : '0;

    always_ff @(posedge wrclk) begin
        if (wr_rst) begin
            state      <= IDLE;
            owner_q    <= '0;
            cnt        <= '0;
            last_owner <= OW'(NREQ - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        owner_q <= pick;
                        cnt     <= '0;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req[owner_q] || (accept && last_word)) begin
                        state      <= IDLE;
                        last_owner <= owner_q;
                        cnt        <= '0;
                    end else if (accept) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: cycle model, word scoreboard,
// directed scenarios and a random soak.
module tb_fifo_wr_arbiter;

    localparam int W = 8;
    localparam int N = 4;
    localparam int B = 4;

    logic             wrclk = 1'b0;
    logic             wr_rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     gnt;
    logic             full;
    logic             push;
    logic [W-1:0]     data_in;
    logic [1:0]       owner;
    logic             owner_vld;

    fifo_wr_arbiter #(.WIDTH(W), .NREQ(N), .BURST(B)) dut (
        .wrclk     (wrclk),
        .wr_rst    (wr_rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .full      (full),
        .push      (push),
        .data_in   (data_in),
        .owner     (owner),
        .owner_vld (owner_vld)
    );

    always #5 wrclk = ~wrclk;

    int total = 0;
    int bad   = 0;

    int m_st, m_own, m_cnt, m_last;

    logic [W-1:0] sbq[$];
    logic [W-1:0] pw[$];
    int           gq[$];
    int           dut_words = 0;
    int           mdl_words = 0;
    logic         p_vld = 1'b0;

    logic         o_push, o_vld;
    logic [N-1:0] o_gnt;
    logic [1:0]   o_owner;
    logic [W-1:0] o_data;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_d(input int i, input logic [W-1:0] v);
        req_data[i*W +: W] = v;
    endtask

    task automatic step();
        logic         e_push, e_vld;
        logic [N-1:0] e_gnt;
        logic [W-1:0] e_data;
        int           nx;
        #1;
        e_push = 1'b0;
        e_vld  = 1'b0;
        e_gnt  = '0;
        e_data = '0;
        if (!wr_rst && m_st == 1) begin
            e_vld  = 1'b1;
            e_data = req_data[m_own*W +: W];
            if (req[m_own] && !full) begin
                e_push       = 1'b1;
                e_gnt[m_own] = 1'b1;
            end
        end
        o_push  = push;
        o_vld   = owner_vld;
        o_gnt   = gnt;
        o_owner = owner;
        o_data  = data_in;
        chk("push", push, e_push);
        chk("gnt", gnt, e_gnt);
        chk("vld", owner_vld, e_vld);
        chk("data", data_in, e_data);
        if (e_vld) chk("owner", owner, m_own);
        chk("gnt_oh", $onehot0(gnt), 1);
        chk("push_full", push & full, 0);
        if (owner_vld && !p_vld) gq.push_back(int'(owner));
        p_vld = owner_vld;
        if (e_push) begin
            sbq.push_back(e_data);
            mdl_words++;
        end
        if (push) begin
            dut_words++;
            pw.push_back(data_in);
            if (sbq.size() == 0) chk("sb_empty", 1, 0);
            else chk("sb_data", data_in, sbq.pop_front());
        end
        if (wr_rst) begin
            m_st = 0; m_cnt = 0; m_own = 0; m_last = N - 1;
        end else if (m_st == 0) begin
            if (req != 0) begin
                nx = m_last;
                do nx = (nx + 1) % N; while (!req[nx]);
                m_own = nx;
                m_st  = 1;
                m_cnt = 0;
            end
        end else begin
            if (!req[m_own]) begin
                m_last = m_own;
                m_st   = 0;
            end else if (!full) begin
                m_cnt++;
                if (m_cnt == B) begin
                    m_last = m_own;
                    m_st   = 0;
                end
            end
        end
        @(posedge wrclk);
        #1;
    endtask

    task automatic do_reset();
        wr_rst   = 1'b1;
        req      = '0;
        full     = 1'b0;
        req_data = '0;
        step();
        chk("rst_push", o_push, 0);
        chk("rst_vld", o_vld, 0);
        chk("rst_data", o_data, 0);
        step();
        wr_rst = 1'b0;
        gq.delete();
        pw.delete();
    endtask

    int pushes;

    initial begin
        do_reset();
        // single producer burst
        req = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            set_d(0, W'(8'hA0 + c - 1));
            step();
            if (c == 0) chk("t1_idle0", o_vld, 0);
            if (c >= 1 && c <= 4) chk("t1_push", o_push, 1);
            if (c == 5) chk("t1_idle5", o_vld, 0);
        end
        chk("t1_nwords", pw.size(), 4);
        for (int i = 0; i < 4 && i < pw.size(); i++)
            chk("t1_word", pw[i], 8'hA0 + i);

        // all requesting: rotation and one idle cycle per burst
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < N; i++) set_d(i, W'(8'h10 * (i + 1)));
        pushes = 0;
        for (int c = 0; c < 25; c++) begin
            step();
            if (o_push) pushes++;
        end
        chk("t2_pushes", pushes, 20);
        chk("t2_ngrants", gq.size(), 5);
        for (int i = 0; i < 5 && i < gq.size(); i++)
            chk("t2_order", gq[i], i % N);

        // full stall mid-burst
        do_reset();
        req = 4'b0100;
        set_d(2, 8'h5C);
        step();
        step(); chk("t3_p1", o_push, 1);
        step(); chk("t3_p2", o_push, 1);
        full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t3_stall_push", o_push, 0);
            chk("t3_stall_gnt", o_gnt, 0);
            chk("t3_stall_own", o_owner, 2);
        end
        full = 1'b0;
        step(); chk("t3_p3", o_push, 1);
        step(); chk("t3_p4", o_push, 1);
        req = 4'b0000;
        step(); chk("t3_rel", o_vld, 0);

        // owner drops request early
        do_reset();
        req = 4'b1010;
        step();
        step();
        chk("t4_own1", o_owner, 1);
        chk("t4_p", o_push, 1);
        req = 4'b1000;
        step(); chk("t4_drop", o_push, 0);
        step(); chk("t4_idle", o_vld, 0);
        step();
        chk("t4_vld3", o_vld, 1);
        chk("t4_own3", o_owner, 3);

        // reset mid-burst
        do_reset();
        req = 4'b0001;
        step();
        step();
        step();
        wr_rst = 1'b1;
        step();
        chk("t5_rst_push", o_push, 0);
        chk("t5_rst_gnt", o_gnt, 0);
        wr_rst = 1'b0;
        req = 4'b1111;
        step();
        step();
        chk("t5_first", o_owner, 0);
        chk("t5_first_vld", o_vld, 1);

        // random soak
        for (int c = 0; c < 10000; c++) begin
            req      = N'($urandom);
            full     = ($urandom_range(0, 3) == 0);
            req_data = N*W'({$urandom, $urandom});
            step();
        end
        chk("words", dut_words, mdl_words);
        chk("sb_left", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data word width and match the FIFO data_in width.
REQ-002 Parameter NREQ, default 4, SHALL set the number of producers (2..8).
REQ-003 Parameter BURST, default 4, SHALL set the maximum words accepted per grant (1..15).
REQ-004 wrclk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 wr_rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-006 req  input  NREQ  SHALL carry per-producer request/valid, bit i = producer i.
REQ-007 req_data  input  NREQ*WIDTH  SHALL carry producer words; slice [i*WIDTH +: WIDTH] = producer i.
REQ-008 gnt  output  NREQ  SHALL flag, per producer, that its word is accepted this cycle (onehot0).
REQ-009 full  input  1  SHALL carry the FIFO full flag, write-clock domain.
REQ-010 push  output  1  SHALL be the FIFO write strobe.
REQ-011 data_in  output  WIDTH  SHALL be the FIFO write data.
REQ-012 owner  output  clog2(NREQ)  SHALL give the current grant holder index, valid when owner_vld=1.
REQ-013 owner_vld  output  1  SHALL be 1 while the block is in state GRANT.

Function
REQ-014 The FSM SHALL have two states, IDLE and GRANT.
REQ-015 In IDLE with req!=0, the block SHALL select the first requesting index in round-robin order starting at (last_owner+1) mod NREQ, register it as owner and enter GRANT next cycle.
REQ-016 In IDLE with req==0, the block SHALL stay in IDLE with push=0 and gnt=0.
REQ-017 In GRANT, accept = req[owner] & ~full; push, data_in and gnt SHALL be combinational: push=accept, gnt[owner]=accept, all other gnt bits 0, data_in=req_data slice of owner.
REQ-018 data_in SHALL equal the owner slice whenever owner_vld=1, regardless of accept; 0 in IDLE.
REQ-019 A burst counter (width clog2(BURST+1)) SHALL clear on entry to GRANT and increment on each accept.
REQ-020 GRANT SHALL return to IDLE at the edge where the accepting word brings the count to BURST, or when req[owner]=0 is sampled.
REQ-021 When full=1 in GRANT, push and gnt SHALL be 0, counter and owner SHALL hold, and the grant SHALL be kept with no timeout.
REQ-022 last_owner SHALL update to owner on every GRANT->IDLE transition; a producer SHALL never be regranted while another requester is waiting.
REQ-023 Minimum latency SHALL be: req rising in IDLE at cycle n -> first push at cycle n+1 (full=0).
REQ-024 Each grant SHALL cost exactly one IDLE arbitration cycle; peak throughput SHALL be BURST words per BURST+1 cycles.
REQ-025 push SHALL never be 1 in a cycle where full=1.

Reset
REQ-026 While wr_rst=1, state SHALL be IDLE, counter 0, owner 0, owner_vld 0, push 0, gnt 0, data_in 0.
REQ-027 last_owner SHALL reset to NREQ-1 so producer 0 wins the first arbitration.
REQ-028 Reset asserted in GRANT SHALL drop push and gnt in the same cycle; the partial burst SHALL be abandoned.

Verification
REQ-029 Reset, req=4'b0001, full=0, BURST=4, data 0xA0..0xA3 -> owner_vld cycle 1, push on cycles 1-4, data_in A0,A1,A2,A3, IDLE cycle 5.
REQ-030 req=4'b1111 held, full=0 -> grant order 0,1,2,3,0; each 4 pushes followed by 1 idle cycle.
REQ-031 Owner 2 after 2 accepts, full=1 for 3 cycles -> push=0, gnt=0, owner stays 2; 2 more pushes after full drops, then release.
REQ-032 Owner 1 drops req after 1 accept while req[3]=1 -> IDLE next cycle, owner 3 on the following cycle.
REQ-033 wr_rst in the middle of a 4-word burst -> push=0 same cycle; after release producer 0 granted first if requesting.
REQ-034 Random req/full, 10k cycles -> gnt onehot0, push=0 whenever full=1, pushed word count equals the scoreboard count.
